// File: rtl/seg_defs.sv
// Shared constants for the seven-segment display driver: segment codes,
// FSM state encoding and digit counts.
package seg_defs;

    localparam int unsigned NumDigits = 6;
    localparam int unsigned NumBcd    = 5;

    localparam logic [7:0] SegBlank = 8'hFF;
    localparam logic [7:0] SegMinus = 8'hBF;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    // Active-low segment pattern for one BCD digit; dp (bit 7) stays off.
    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] code;
        case (d)
            4'd0:    code = 8'hC0;
            4'd1:    code = 8'hF9;
            4'd2:    code = 8'hA4;
            4'd3:    code = 8'hB0;
            4'd4:    code = 8'h99;
            4'd5:    code = 8'h92;
            4'd6:    code = 8'h82;
            4'd7:    code = 8'hF8;
            4'd8:    code = 8'h80;
            4'd9:    code = 8'h90;
            default: code = SegBlank;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bin2bcd_iter.sv
// Iterative shift-add-3 converter: 16-bit binary to five BCD digits in 16 cycles.
module bin2bcd_iter
    import seg_defs::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        done,
    output logic [19:0] bcd
);

    logic [35:0] sh_q;
    logic [35:0] sh_d;
    logic [35:0] adj;
    logic [3:0]  cnt_q;
    logic        run_q;

    always_comb begin
        adj = sh_q;
        for (int i = 0; i < int'(NumBcd); i++) begin
            if (sh_q[16 + 4 * i +: 4] >= 4'd5) begin
                adj[16 + 4 * i +: 4] = sh_q[16 + 4 * i +: 4] + 4'd3;
            end
        end
        sh_d = {adj[34:0], 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            sh_q  <= {20'd0, bin};
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            sh_q  <= sh_d;
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
                run_q <= 1'b0;
            end
        end
    end

    // High during the final shift; bcd holds the result from the next cycle on.
    assign done = run_q && (cnt_q == 4'd15);
    assign bcd  = sh_q[35:16];

endmodule

// File: rtl/seg_display_driver.sv
// Converts a signed magnitude to BCD on change and scans it onto a six-digit,
// common-anode seven-segment display with leading-zero blanking.
module seg_display_driver
    import seg_defs::*;
#(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] bin_data,
    input  logic        seg_sign,
    output logic [7:0]  seg,
    output logic [5:0]  dig_sel,
    output logic        busy
);

    localparam int unsigned PreW = $clog2(SCAN_DIV);
    localparam logic [PreW-1:0] PreMax = PreW'(SCAN_DIV - 1);

    state_e      state_q, state_d;
    logic [15:0] last_bin_q;
    logic        last_sign_q;
    logic        stale_q;
    logic        start;
    logic        load_disp;
    logic        conv_done;
    logic [19:0] bcd;

    logic [19:0] disp_bcd_q;
    logic        disp_sign_q;
    logic        disp_valid_q;

    logic [PreW-1:0] pre_q;
    logic [2:0]      idx_q;
    logic            tick;
    logic [23:0]     disp_ext;
    logic [7:0]      cur_seg;
    logic [7:0]      seg_q;
    logic [5:0]      dig_sel_q;

    bin2bcd_iter u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin_data),
        .done  (conv_done),
        .bcd   (bcd)
    );

    always_comb begin
        state_d   = state_q;
        start     = 1'b0;
        load_disp = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (stale_q || ({seg_sign, bin_data} != {last_sign_q, last_bin_q})) begin
                    start   = 1'b1;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (conv_done) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                load_disp = 1'b1;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_bin_q   <= '0;
            last_sign_q  <= 1'b0;
            stale_q      <= 1'b1;
            disp_bcd_q   <= '0;
            disp_sign_q  <= 1'b0;
            disp_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                last_bin_q  <= bin_data;
                last_sign_q <= seg_sign;
                stale_q     <= 1'b0;
            end
            if (load_disp) begin
                disp_bcd_q   <= bcd;
                disp_sign_q  <= last_sign_q;
                disp_valid_q <= 1'b1;
            end
        end
    end

    assign busy = (state_q != StIdle);

    assign tick     = (pre_q == PreMax);
    assign disp_ext = {4'd0, disp_bcd_q};

    // A digit is shown only if it or some higher digit is nonzero; digit 0 always shows.
    always_comb begin
        cur_seg = SegBlank;
        if (disp_valid_q) begin
            if (idx_q == 3'd5) begin
                cur_seg = (disp_sign_q && (disp_bcd_q != 20'd0)) ? SegMinus : SegBlank;
            end else if ((idx_q == 3'd0) || ((disp_ext >> {idx_q, 2'b00}) != 24'd0)) begin
                cur_seg = seg_code(disp_ext[{idx_q, 2'b00} +: 4]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q     <= '0;
            idx_q     <= '0;
            seg_q     <= SegBlank;
            dig_sel_q <= 6'b111110;
        end else begin
            pre_q <= tick ? '0 : pre_q + 1'b1;
            if (tick) begin
                idx_q <= (idx_q == 3'(NumDigits - 1)) ? 3'd0 : idx_q + 3'd1;
            end
            seg_q     <= cur_seg;
            dig_sel_q <= ~(6'b000001 << idx_q);
        end
    end

    assign seg     = seg_q;
    assign dig_sel = dig_sel_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver: expected frames are queued when a value
// is applied and compared digit by digit as the display scans them out.
module tb_seg_display_driver;

    localparam int unsigned ScanDiv = 4;

    typedef struct packed {
        logic [5:0] sel;
        logic [7:0] seg;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bin_data;
    logic        seg_sign;
    logic [7:0]  seg;
    logic [5:0]  dig_sel;
    logic        busy;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    exp_t        exp_q[$];

    seg_display_driver #(
        .SCAN_DIV (ScanDiv)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bin_data (bin_data),
        .seg_sign (seg_sign),
        .seg      (seg),
        .dig_sel  (dig_sel),
        .busy     (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] code_of(input int unsigned d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(input int unsigned v, input bit s, input int k);
        int unsigned p;
        if (k == 5) return (s && v != 0) ? 8'hBF : 8'hFF;
        p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (k > 0 && v < p) return 8'hFF;
        return code_of((v / p) % 10);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_expected(input int unsigned v, input bit s);
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            e.sel    = 6'b111111;
            e.sel[k] = 1'b0;
            e.seg    = exp_seg(v, s, k);
            exp_q.push_back(e);
        end
    endtask

    // Waits up to a few cycles for busy to rise, then checks it stays high 17 cycles.
    task automatic measure_busy(input string tag);
        int n;
        n = 0;
        while (!busy && n < 5) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check({tag, "_busy_len"}, 32'(n), 32'd17);
    endtask

    task automatic check_frame(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (dig_sel == 6'b111110 && n < 40) begin
            @(negedge clk);
            n++;
        end
        while (dig_sel != 6'b111110 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_frame_align"}, 32'(n < 40), 32'd1);
        for (int k = 0; k < 6; k++) begin
            e = exp_q.pop_front();
            check($sformatf("%s_sel%0d", tag, k), 32'(dig_sel), 32'(e.sel));
            check($sformatf("%s_seg%0d", tag, k), 32'(seg), 32'(e.seg));
            repeat (ScanDiv) @(negedge clk);
        end
        check({tag, "_sel_wrap"}, 32'(dig_sel), 32'h3E);
    endtask

    task automatic apply(input string tag, input int unsigned v, input bit s);
        @(negedge clk);
        bin_data = 16'(v);
        seg_sign = s;
        push_expected(v, s);
        measure_busy(tag);
        check_frame(tag);
    endtask

    initial begin
        int          n;
        int          pos;
        int unsigned t0;

        rst      = 1'b1;
        bin_data = 16'd0;
        seg_sign = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_seg", 32'(seg), 32'hFF);
        check("rst_sel", 32'(dig_sel), 32'h3E);
        check("rst_busy", 32'(busy), 32'd0);

        // First value converts even though it equals the reset latch contents.
        push_expected(0, 1'b0);
        rst = 1'b0;
        measure_busy("zero");
        check_frame("zero");

        apply("v12345", 12345, 1'b0);
        apply("v65535n", 65535, 1'b1);
        apply("v7n", 7, 1'b1);
        apply("negzero", 0, 1'b1);

        // Change arrives mid-conversion: 100 completes, then 200 is captured.
        @(negedge clk);
        bin_data = 16'd100;
        seg_sign = 1'b0;
        n = 0;
        while (!busy && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("b2b_rise", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        bin_data = 16'd200;
        t0 = cyc;
        push_expected(200, 1'b0);
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        pos = 0;
        for (int k = 0; k < 6; k++) if (!dig_sel[k]) pos = k;
        check("b2b_first_val", 32'(seg), 32'(exp_seg(100, 1'b0, pos)));
        check("b2b_recapture", 32'(busy), 32'd1);
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("b2b_converge", 32'((cyc - t0) <= 36), 32'd1);
        check_frame("b2b");

        // Reset in the middle of a conversion.
        @(negedge clk);
        bin_data = 16'd4321;
        n = 0;
        while (!busy && n < 5) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_seg", 32'(seg), 32'hFF);
        check("midrst_sel", 32'(dig_sel), 32'h3E);
        check("midrst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        push_expected(4321, 1'b0);
        rst = 1'b0;
        measure_busy("v4321");
        check_frame("v4321");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_display_driver.md
# seg_display_driver

Consumes the 16-bit magnitude (`bin_data`) and sign flag (`seg_sign`) produced by the calculator's result store. Converts the value to five BCD digits with an iterative shift-add-3 engine and drives a six-digit, multiplexed, common-anode seven-segment display. Digit 5 is the sign position; leading zeros are blanked. This block sits between the result store and the board's display pins.

## Interface

- `SCAN_DIV`, default 50000: clk cycles each digit stays selected; minimum 2; benches use 4.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `bin_data`  in  16  unsigned magnitude, 0..65535.
- `seg_sign`  in  1  1 = negative.
- `seg`  out  8  segment drive, active-low; `[6:0]` = g..a, `[7]` = dp (always 1, off).
- `dig_sel`  out  6  digit enable, active-low one-hot; bit 0 is the rightmost digit.
- `busy`  out  1  high while a conversion is in progress.

## Operation

- Input latch `{last_sign, last_bin}` plus a `stale` flag.
  - Reset sets `stale` = 1, so the first value is always converted.
- FSM states:
  - IDLE: if `stale` or `{seg_sign, bin_data}` differs from the latch, capture the inputs into the latch, clear `stale`, load the shifter, and go to SHIFT.
  - SHIFT: 16 cycles. Each cycle, add 3 to every BCD nibble that is ≥ 5, then shift left by one, bringing in the next `bin_data` bit (MSB first). A 4-bit iteration counter counts 0..15. On count 15, go to DONE.
  - DONE: one cycle. Copy the 5 BCD nibbles and the sign into the display register atomically, then return to IDLE.
- Input changes during SHIFT or DONE are ignored. On return to IDLE the compare runs again, so the display always converges to the last stable input.
- Display-register decode:
  - Digit 0 always shows its BCD value.
  - Digits 4..1 are blank (8'hFF) while they and every higher digit are 0.
  - Digit 5 shows minus (8'hBF) when the sign is set and the value is nonzero; otherwise it is blank. Negative zero displays as "0".
  - Codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and pulses a tick when it wraps.
  - On each tick the digit index advances 0→1→…→5→0.
  - `seg` and `dig_sel` are registered from the index and decode.
- Reset values:
  - `seg` = 8'hFF, `dig_sel` = 6'b111110, `busy` = 0.
  - FSM = IDLE, index = 0, prescaler = 0.
  - Display register = all blank.

## Timing

- Capture edge = the edge on which IDLE samples a change.
- `busy` is high from the capture edge +1 through the DONE cycle, i.e. 17 cycles.
- The display register updates on the edge ending DONE, 17 cycles after capture.
- The update appears on `seg` at the next scan tick for each digit; the currently selected digit updates 1 cycle after the display register.
- `dig_sel` changes 1 cycle after each tick. Each digit is held for exactly SCAN_DIV cycles; a full frame is 6·SCAN_DIV.
- Tick and DONE in the same cycle: the new digit uses the new display contents. No mixed old/new frame contents for a single digit.
- Back-to-back changes: worst-case convergence is 2×18 cycles after the last input change.
- `rst` mid-conversion: outputs take their reset values immediately (asynchronous). The conversion is discarded and reruns after release because `stale` = 1.

## Structure

- Shared package/include `seg_defs`:
  - the segment constants (digits 0–9, blank, minus);
  - FSM state encodings;
  - digit count 6 and BCD digit count 5.
- Sub-module `bin2bcd_iter`:
  - owns the shifter, add-3 logic and iteration counter;
  - handshake is `start` / `done` / `bcd[19:0]`.
- Top level owns the change detect, display register, scan prescaler and decode.

## Test plan

- Reset, then `bin_data`=0, `seg_sign`=0, SCAN_DIV=4 -> `busy` high for 17 cycles; over one frame, digit 0 = C0 and digits 1–5 = FF; `dig_sel` steps 111110→111101→…→011111→111110 every 4 cycles.
- `bin_data`=12345, sign 0 -> digits 4..0 = F9, A4, B0, 99, 92; digit 5 = FF.
- `bin_data`=65535, sign 1 -> digits 4..0 = 82, 92, 92, B0, 92; digit 5 = BF.
- `bin_data`=7, sign 1, then 0 with sign 1 -> first shows digit 0 = F8, digits 1–4 FF, digit 5 BF; then digit 0 = C0 and digit 5 = FF (no minus).
- `bin_data`=100, then 200 applied 5 cycles after capture -> first conversion completes showing 100; a second capture follows; final display is 200 within 36 cycles of the change.
- Assert `rst` 8 cycles into the conversion of 4321 -> `seg`=FF, `dig_sel`=111110, `busy`=0 immediately; after release, 4321 is displayed 18 cycles later.
